// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master.
//   Configurable word width, NUM_SS active-low slave selects, all four
//   CPOL/CPHA modes, MSB/LSB-first ordering and a programmable SCK
//   half-period H = i_clk_div + 1 system clocks.
//
// Optional build macro: SPI_MASTER_CONT_EN
//   Defined   : continuous mode. A request present on the last SCK edge of
//               a word chains the next word with SS held low and no gap in
//               the SCK rhythm.
//   Undefined : every word is a separate transaction (SS released between).
//
// Ports
//   i_sys_clk, i_sys_rst      clock, asynchronous active-low reset
//   i_trans_en                transfer request (level), accepted in IDLE
//   i_data                    TX word, captured at acceptance
//   i_ss_sel                  slave index, captured at acceptance
//   i_cpol, i_cpha            SPI mode, captured at acceptance
//   i_lsb_first               1 = LSB first, captured at acceptance
//   i_clk_div                 SCK half-period minus one, captured at acceptance
//   i_MISO                    serial data in
//   o_SCK, o_MOSI, o_SS       SPI pins (o_SS active-low, one-hot-low)
//   o_busy                    high outside IDLE
//   o_data                    last received word
//   o_interrupt               one-cycle completion pulse
module spi_master_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_SS = 4,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_trans_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_ss_sel,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic              i_MISO,
  output logic              o_SCK,
  output logic              o_MOSI,
  output logic [NUM_SS-1:0] o_SS,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_interrupt
);

  localparam int unsigned     EC_W      = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bit that leaves the shift register first for the selected order.
  function automatic logic f_first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Shift register after the first bit has been sent.
  function automatic logic [DATA_W-1:0] f_shift_out(input logic [DATA_W-1:0] w,
                                                    input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Receive shift so the assembled word ends up in natural bit order.
  function automatic logic [DATA_W-1:0] f_shift_in(input logic [DATA_W-1:0] w,
                                                   input logic b, input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_cpol, r_cpha, r_lsb;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [EC_W-1:0]     r_edge_cnt;
  logic [DATA_W-1:0]   r_tx, r_rx;
  logic                r_sck, r_mosi, r_irq;
  logic [NUM_SS-1:0]   r_ss;
  logic [DATA_W-1:0]   r_data;

  logic                w_cpol_nxt, w_cpha_nxt, w_lsb_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [DIV_W-1:0]    w_div_cnt_nxt;
  logic [EC_W-1:0]     w_edge_cnt_nxt;
  logic [DATA_W-1:0]   w_tx_nxt, w_rx_nxt;
  logic                w_sck_nxt, w_mosi_nxt, w_irq_nxt;
  logic [NUM_SS-1:0]   w_ss_nxt;
  logic [DATA_W-1:0]   w_data_nxt;

  logic                w_accept, w_tick, w_edge, w_last, w_leading;
  logic                w_sample, w_drive, w_cont;
  logic [DATA_W-1:0]   w_rx_in;

  // Request decode and SCK edge qualification.
  assign w_accept  = (r_state == S_IDLE) && i_trans_en && (32'(i_ss_sel) < NUM_SS);
  assign w_tick    = (r_div_cnt == r_div);
  assign w_edge    = (r_state == S_XFER) && w_tick;
  assign w_last    = (r_edge_cnt == LAST_EDGE);
  // Even edge indices move SCK away from CPOL.
  assign w_leading = ~r_edge_cnt[0];
  assign w_sample  = w_edge && (w_leading ^ r_cpha);
  // cpha=0 has no trailing drive after the final bit.
  assign w_drive   = w_edge && (r_cpha ? w_leading : (~w_leading && ~w_last));
  assign w_rx_in   = w_sample ? f_shift_in(r_rx, i_MISO, r_lsb) : r_rx;

`ifdef SPI_MASTER_CONT_EN
  // Chain the next word when a request is present on the final edge.
  assign w_cont = w_edge && w_last && i_trans_en;
`else
  assign w_cont = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tick)   w_state_nxt = S_XFER;
      S_XFER:  if (w_edge && w_last) w_state_nxt = w_cont ? S_XFER : S_HOLD;
      S_HOLD:  if (w_tick)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_cpol_nxt     = r_cpol;
    w_cpha_nxt     = r_cpha;
    w_lsb_nxt      = r_lsb;
    w_div_nxt      = r_div;
    w_div_cnt_nxt  = DIV_W'(0);
    w_edge_cnt_nxt = r_edge_cnt;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;
    w_irq_nxt      = 1'b0;
    w_ss_nxt       = r_ss;
    w_data_nxt     = r_data;

    // Divider runs only while a transfer is in flight.
    if (r_state == S_SETUP || r_state == S_XFER || r_state == S_HOLD) begin
      w_div_cnt_nxt = w_tick ? DIV_W'(0) : r_div_cnt + DIV_W'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        w_sck_nxt  = i_cpol;
        w_mosi_nxt = 1'b0;
        if (w_accept) begin
          w_cpol_nxt     = i_cpol;
          w_cpha_nxt     = i_cpha;
          w_lsb_nxt      = i_lsb_first;
          w_div_nxt      = i_clk_div;
          w_edge_cnt_nxt = EC_W'(0);
          w_rx_nxt       = '0;
          w_ss_nxt       = ~(NUM_SS'(1) << i_ss_sel);
          // cpha=0 presents the first bit before the first edge.
          w_mosi_nxt     = i_cpha ? 1'b0 : f_first_bit(i_data, i_lsb_first);
          w_tx_nxt       = i_cpha ? i_data : f_shift_out(i_data, i_lsb_first);
        end
      end
      S_SETUP: begin
        if (w_tick) w_edge_cnt_nxt = EC_W'(0);
      end
      S_XFER: begin
        if (w_edge) begin
          w_sck_nxt      = ~r_sck;
          w_edge_cnt_nxt = w_last ? EC_W'(0) : r_edge_cnt + EC_W'(1);
          w_rx_nxt       = w_rx_in;
          if (w_drive) begin
            w_mosi_nxt = f_first_bit(r_tx, r_lsb);
            w_tx_nxt   = f_shift_out(r_tx, r_lsb);
          end
          if (w_cont) begin
            w_irq_nxt  = 1'b1;
            w_data_nxt = w_rx_in;
            w_rx_nxt   = '0;
            w_mosi_nxt = r_cpha ? r_mosi : f_first_bit(i_data, r_lsb);
            w_tx_nxt   = r_cpha ? i_data : f_shift_out(i_data, r_lsb);
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_ss_nxt   = '1;
          w_mosi_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_irq_nxt  = 1'b1;
        w_data_nxt = r_rx;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_div      <= '0;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_irq      <= 1'b0;
      r_ss       <= '1;
      r_data     <= '0;
    end else begin
      r_cpol     <= w_cpol_nxt;
      r_cpha     <= w_cpha_nxt;
      r_lsb      <= w_lsb_nxt;
      r_div      <= w_div_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
      r_irq      <= w_irq_nxt;
      r_ss       <= w_ss_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign o_SCK       = r_sck;
  assign o_MOSI      = r_mosi;
  assign o_SS        = r_ss;
  assign o_busy      = (r_state != S_IDLE);
  assign o_data      = r_data;
  assign o_interrupt = r_irq;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, NUM_SS=4, DIV_W=8) plus a
// NUM_SS=6 instance for out-of-range slave indices. A bench-side SPI slave
// records MOSI and shifts out its own word, changing MISO on the edge
// opposite to the one the master samples on.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trans_en = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ss_sel = '0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [7:0] div = 8'd1;
  logic       loop = 1'b0;
  logic       miso;
  logic       sck, mosi, busy, irq;
  logic [3:0] ss;
  logic [7:0] dout;

  logic       trans_en6 = 1'b0;
  logic [2:0] ss_sel6 = '0;
  logic       sck6, mosi6, busy6, irq6;
  logic [5:0] ss6;
  logic [7:0] dout6;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u_dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n), .i_trans_en(trans_en), .i_data(data),
    .i_ss_sel(ss_sel), .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
    .i_clk_div(div), .i_MISO(miso), .o_SCK(sck), .o_MOSI(mosi), .o_SS(ss),
    .o_busy(busy), .o_data(dout), .o_interrupt(irq)
  );

  spi_master_param #(.DATA_W(8), .NUM_SS(6), .DIV_W(8)) u_dut6 (
    .i_sys_clk(clk), .i_sys_rst(rst_n), .i_trans_en(trans_en6), .i_data(data),
    .i_ss_sel(ss_sel6), .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
    .i_clk_div(div), .i_MISO(1'b0), .o_SCK(sck6), .o_MOSI(mosi6), .o_SS(ss6),
    .o_busy(busy6), .o_data(dout6), .o_interrupt(irq6)
  );

  // Slave model.
  logic [7:0] sl_word = '0;
  logic [7:0] sl_seq = '0;
  logic       sl_miso = 1'b0;
  logic       sl_act = 1'b0;
  logic       sl_prev = 1'b0;
  int         sl_drv = 0;

  assign miso = loop ? mosi : sl_miso;

  function automatic logic seq_bit(input logic [7:0] w, input int j, input logic lsbf);
    return lsbf ? w[j] : w[7-j];
  endfunction

  always @(negedge clk) begin
    if (&ss) begin
      sl_act <= 1'b0;
    end else if (!sl_act) begin
      sl_act <= 1'b1;
      sl_seq <= '0;
      sl_drv <= cpha ? 0 : 1;
      if (!cpha) sl_miso <= seq_bit(sl_word, 0, lsb);
    end else if (sck !== sl_prev) begin
      if ((sck !== cpol) ^ cpha) begin
        sl_seq <= {sl_seq[6:0], mosi};
      end else if (sl_drv < 8) begin
        sl_miso <= seq_bit(sl_word, sl_drv, lsb);
        sl_drv  <= sl_drv + 1;
      end
    end
    sl_prev <= sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on u_dut with timing, pin and data checks.
  task automatic run_xfer(input string tag, input logic [7:0] d, input logic [1:0] sel,
                          input logic pol, input logic pha, input logic lsbf,
                          input logic [7:0] dv, input logic lp, input logic [7:0] sw,
                          input logic [7:0] exp_rx);
    int h, exp_lat, lat, n_edges, first, last_e, gap_bad, ss_low;
    logic prev;
    logic [3:0] exp_ss;
    logic [7:0] exp_seq;
    h       = int'(dv) + 1;
    exp_lat = 1 + h + 16 * h + h;
    exp_ss  = ~(4'b0001 << sel);
    for (int i = 0; i < 8; i++) exp_seq[i] = lsbf ? d[7-i] : d[i];
    @(negedge clk);
    data = d; ss_sel = sel; cpol = pol; cpha = pha; lsb = lsbf;
    div = dv; loop = lp; sl_word = sw; trans_en = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s.idle_sck", tag), sck, pol);
    @(negedge clk); trans_en = 1'b1;
    @(posedge clk); #1; trans_en = 1'b0;
    chk($sformatf("%s.ss_on", tag), ss, exp_ss);
    chk($sformatf("%s.busy_on", tag), busy, 1'b1);
    ss_low = (ss === exp_ss) ? 1 : 0;
    prev = sck; n_edges = 0; first = 0; last_e = 0; gap_bad = 0; lat = 0;
    for (int c = 1; c <= exp_lat + 40; c++) begin
      @(posedge clk); #1;
      if (sck !== prev) begin
        n_edges++;
        if (n_edges == 1) first = c;
        else if (c - last_e != h) gap_bad++;
        last_e = c;
        prev = sck;
      end
      if (ss === exp_ss) ss_low++;
      if (irq === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("%s.latency", tag), lat, exp_lat);
    chk($sformatf("%s.sck_edges", tag), n_edges, 16);
    chk($sformatf("%s.sck_first", tag), first, 2 * h);
    chk($sformatf("%s.sck_gaps", tag), gap_bad, 0);
    chk($sformatf("%s.ss_low_cycles", tag), ss_low, exp_lat - 1);
    chk($sformatf("%s.rx", tag), dout, exp_rx);
    chk($sformatf("%s.mosi_seq", tag), sl_seq, exp_seq);
    chk($sformatf("%s.ss_off", tag), ss, 4'hF);
    chk($sformatf("%s.busy_off", tag), busy, 1'b0);
    chk($sformatf("%s.sck_end", tag), sck, pol);
    @(posedge clk); #1;
    chk($sformatf("%s.irq_pulse", tag), irq, 1'b0);
  endtask

  initial begin
    int n, c, nirq, ss_high;
    logic prev, seen_busy, seen_ss, seen_irq, got;
    int irq_t[3];
    logic [7:0] dvals[3];

    // Reset values.
    #12;
    chk("rst.ss", ss, 4'hF);
    chk("rst.sck", sck, 1'b0);
    chk("rst.mosi", mosi, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.data", dout, 8'h00);
    chk("rst.irq", irq, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Mode 0 MSB first, H=2.
    run_xfer("m0", 8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h3C, 8'h3C);
    // Modes 1/2/3, LSB first.
    run_xfer("m1", 8'h81, 2'd0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 8'hC6, 8'hC6);
    run_xfer("m2", 8'h81, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 8'hC6, 8'hC6);
    run_xfer("m3", 8'h81, 2'd3, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'h4B, 8'h4B);
    // Divider extremes with loopback.
    run_xfer("div0", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 8'h5A);
    run_xfer("divff", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h5A);

    // Reset after the third SCK edge.
    @(negedge clk);
    data = 8'hC3; ss_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    div = 8'd1; loop = 1'b0; sl_word = 8'h99; trans_en = 1'b1;
    @(posedge clk); #1; trans_en = 1'b0;
    n = 0; prev = sck;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sck !== prev) begin n++; prev = sck; end
      if (n == 3) break;
    end
    chk("rst_mid.edges", n, 3);
    rst_n = 1'b0; #1;
    chk("rst_mid.ss", ss, 4'hF);
    chk("rst_mid.sck", sck, 1'b0);
    chk("rst_mid.busy", busy, 1'b0);
    seen_irq = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen_irq |= irq; end
    chk("rst_mid.no_irq", seen_irq, 1'b0);
    chk("rst_mid.data", dout, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    run_xfer("after_rst", 8'hFF, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h0F, 8'h0F);

    // Out-of-range slave index on the NUM_SS=6 instance.
    seen_busy = 1'b0; seen_ss = 1'b0; seen_irq = 1'b0;
    for (int s = 6; s < 8; s++) begin
      @(negedge clk); ss_sel6 = 3'(s); trans_en6 = 1'b1;
      repeat (12) begin
        @(posedge clk); #1;
        seen_busy |= busy6; seen_irq |= irq6; seen_ss |= (ss6 !== 6'h3F);
      end
    end
    @(negedge clk); trans_en6 = 1'b0;
    chk("ss_oor.busy", seen_busy, 1'b0);
    chk("ss_oor.ss", seen_ss, 1'b0);
    chk("ss_oor.irq", seen_irq, 1'b0);
    // Highest legal index is accepted.
    @(negedge clk); ss_sel6 = 3'd5; div = 8'd1; trans_en6 = 1'b1;
    @(posedge clk); #1; trans_en6 = 1'b0;
    chk("ss_max.ss", ss6, 6'b011111);
    chk("ss_max.busy", busy6, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (irq6 === 1'b1) begin got = 1'b1; break; end
    end
    chk("ss_max.irq", got, 1'b1);
    chk("ss_max.data", dout6, 8'h00);

    // Three words with i_trans_en held high, loopback, mode 0, H=2.
    @(negedge clk);
    data = 8'h11; ss_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    div = 8'd1; loop = 1'b1; trans_en = 1'b1;
    @(posedge clk); #1; data = 8'h22;
    c = 0; nirq = 0; ss_high = 0;
    irq_t[0] = 0; irq_t[1] = 0; irq_t[2] = 0;
    dvals[0] = '0; dvals[1] = '0; dvals[2] = '0;
    while (nirq < 3 && c < 400) begin
      @(posedge clk); #1; c++;
      if (&ss) ss_high++;
      if (irq === 1'b1) begin
        irq_t[nirq] = c; dvals[nirq] = dout; nirq++;
      end
      if (nirq >= 1 && c == irq_t[0] + 2) data = 8'h33;
      if (nirq >= 2 && c == irq_t[1] + 2) trans_en = 1'b0;
    end
    trans_en = 1'b0;
    chk("stream.count", nirq, 3);
    chk("stream.d0", dvals[0], 8'h11);
    chk("stream.d1", dvals[1], 8'h22);
    chk("stream.d2", dvals[2], 8'h33);
`ifdef SPI_MASTER_CONT_EN
    chk("stream.lat0", irq_t[0], 34);
    chk("stream.gap01", irq_t[1] - irq_t[0], 32);
    chk("stream.gap12", irq_t[2] - irq_t[1], 32);
    chk("stream.ss_high", ss_high, 2);
`else
    chk("stream.lat0", irq_t[0], 37);
    chk("stream.gap01", irq_t[1] - irq_t[0], 38);
    chk("stream.gap12", irq_t[2] - irq_t[1], 38);
    chk("stream.ss_high", ss_high, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
